// File: rtl/sa_pkg.sv
// Shared types and helpers for the parametrised output-stationary systolic array.
package sa_pkg;

  // Job sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sa_state_e;

  // Bits needed to count 0 .. n-1; never less than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // LSB of lane idx in a flat bus of w-bit lanes.
  function automatic int lane_lsb(input int idx, input int w);
    return idx * w;
  endfunction

  // LSB of element (i,j) in a flat row-major n x n bus of w-bit elements.
  function automatic int res_lsb(input int i, input int j, input int n, input int w);
    return (i * n + j) * w;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// One processing element: forwards a right and b down with one cycle of latency,
// and accumulates a*b into a private accumulator when both operands are tagged valid.
module sa_pe
  import sa_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 64,
  parameter int SIGNED = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Clr,
  input  logic [DW-1:0] a_in,
  input  logic          a_vld_in,
  input  logic [DW-1:0] b_in,
  input  logic          b_vld_in,
  output logic [DW-1:0] a_out,
  output logic          a_vld_out,
  output logic [DW-1:0] b_out,
  output logic          b_vld_out,
  output logic [AW-1:0] acc
);

  logic            sgn_a;
  logic            sgn_b;
  logic [2*DW-1:0] a_x;
  logic [2*DW-1:0] b_x;
  logic [2*DW-1:0] prod;
  logic [AW-1:0]   prod_ext;

  // Operands are widened to the full product width first, so the low 2*DW bits
  // of the product are exact for both signed and unsigned interpretation.
  assign sgn_a = (SIGNED != 0) & a_in[DW-1];
  assign sgn_b = (SIGNED != 0) & b_in[DW-1];
  assign a_x   = {{DW{sgn_a}}, a_in};
  assign b_x   = {{DW{sgn_b}}, b_in};
  assign prod  = a_x * b_x;

  // Extend the 2*DW-bit product to accumulator width (sign or zero fill).
  if (AW > 2 * DW) begin : g_ext
    logic fill;
    assign fill     = (SIGNED != 0) & prod[2*DW-1];
    assign prod_ext = {{(AW - 2 * DW){fill}}, prod};
  end else begin : g_noext
    assign prod_ext = prod;
  end

  // Operand forwarding and wrap-around accumulation; Clr starts a new job.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_out     <= '0;
      a_vld_out <= 1'b0;
      b_out     <= '0;
      b_vld_out <= 1'b0;
      acc       <= '0;
    end else begin
      a_out     <= a_in;
      a_vld_out <= a_vld_in;
      b_out     <= b_in;
      b_vld_out <= b_vld_in;
      if (Clr) begin
        acc <= '0;
      end else if (a_vld_in && b_vld_in) begin
        acc <= acc + prod_ext;
      end
    end
  end

endmodule

// File: rtl/systolic_array_param.sv
// N x N output-stationary systolic matrix multiplier, C = A(NxK) * B(KxN).
// Unskewed beats (one A column, one B row) are skewed internally; a valid tag
// travels with each operand so input bubbles contribute nothing.
module systolic_array_param
  import sa_pkg::*;
#(
  parameter int N      = 4,
  parameter int DW     = 32,
  parameter int AW     = 64,
  parameter int KW     = 8,
  parameter int SIGNED = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [KW-1:0]     K_Len,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [N*DW-1:0]   A_Col,
  input  logic [N*DW-1:0]   B_Row,
  output logic              Busy,
  output logic              Done,
  output logic [N*N*AW-1:0] Result
);

  // The last beat needs 2N-1 edges to reach PE(N-1,N-1).
  localparam int             DCW        = cnt_w(2 * N - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2 * N - 2);

  sa_state_e      state;
  logic [KW-1:0]  k_len;
  logic [KW-1:0]  beat_cnt;
  logic [DCW-1:0] drain_cnt;
  logic           xfer;
  logic           start_ok;

  // Operand/tag grid: a flows along rows (column index N is the exit),
  // b flows down columns (row index N is the exit).
  logic [DW-1:0] a_h  [N][N+1];
  logic          av_h [N][N+1];
  logic [DW-1:0] b_v  [N+1][N];
  logic          bv_v [N+1][N];
  logic [AW-1:0] acc  [N][N];
  logic          unused_edge;

  assign xfer     = In_Valid && In_Ready;
  assign start_ok = Start && ((state == IDLE) || (state == DONE));

  // Job sequencer with registered handshake/status outputs.
  // NOTE: clocked blocks use non-blocking assignments only, so every register
  // here sees the pre-edge value of every other register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      k_len     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      In_Ready  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (Start) begin
            k_len     <= K_Len;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            Busy      <= 1'b1;
            if (K_Len == '0) begin
              state    <= DRAIN;
              In_Ready <= 1'b0;
            end else begin
              state    <= LOAD;
              In_Ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            if (beat_cnt == k_len - KW'(1)) begin
              state     <= DRAIN;
              In_Ready  <= 1'b0;
              drain_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + KW'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          In_Ready <= 1'b0;
          Busy     <= 1'b0;
          Done     <= 1'b0;
        end
      endcase
    end
  end

  // Row i of A enters the array i cycles later than row 0.
  for (genvar gi = 0; gi < N; gi++) begin : g_a_skew
    logic [DW-1:0] d [gi+1];
    logic          v [gi+1];

    // Shift A lane gi and its transfer tag through gi+1 registers.
    // NOTE: the skew arrays are plain flops and are cleared element by element,
    // so no stale operand can ever carry a valid tag out of reset.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        for (int s = 0; s <= gi; s++) begin
          d[s] <= '0;
          v[s] <= 1'b0;
        end
      end else begin
        d[0] <= A_Col[lane_lsb(gi, DW) +: DW];
        v[0] <= xfer;
        for (int s = 1; s <= gi; s++) begin
          d[s] <= d[s-1];
          v[s] <= v[s-1];
        end
      end
    end

    assign a_h[gi][0]  = d[gi];
    assign av_h[gi][0] = v[gi];
  end

  // Column j of B enters the array j cycles later than column 0.
  for (genvar gj = 0; gj < N; gj++) begin : g_b_skew
    logic [DW-1:0] d [gj+1];
    logic          v [gj+1];

    // Shift B lane gj and its transfer tag through gj+1 registers.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        for (int s = 0; s <= gj; s++) begin
          d[s] <= '0;
          v[s] <= 1'b0;
        end
      end else begin
        d[0] <= B_Row[lane_lsb(gj, DW) +: DW];
        v[0] <= xfer;
        for (int s = 1; s <= gj; s++) begin
          d[s] <= d[s-1];
          v[s] <= v[s-1];
        end
      end
    end

    assign b_v[0][gj]  = d[gj];
    assign bv_v[0][gj] = v[gj];
  end

  // N x N grid of processing elements.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      sa_pe #(
        .DW     (DW),
        .AW     (AW),
        .SIGNED (SIGNED)
      ) u_pe (
        .Clk       (Clk),
        .Reset     (Reset),
        .Clr       (start_ok),
        .a_in      (a_h[gi][gj]),
        .a_vld_in  (av_h[gi][gj]),
        .b_in      (b_v[gi][gj]),
        .b_vld_in  (bv_v[gi][gj]),
        .a_out     (a_h[gi][gj+1]),
        .a_vld_out (av_h[gi][gj+1]),
        .b_out     (b_v[gi+1][gj]),
        .b_vld_out (bv_v[gi+1][gj]),
        .acc       (acc[gi][gj])
      );

      assign Result[res_lsb(gi, gj, N, AW) +: AW] = acc[gi][gj];
    end
  end

  // Operands leaving the right and bottom edges have no consumer; fold them
  // into one sink so they are visibly intentional.
  // NOTE: the default is assigned before the loop so every path writes it and
  // no latch can be inferred.
  always_comb begin
    unused_edge = 1'b0;
    for (int i = 0; i < N; i++) begin
      unused_edge = unused_edge ^ (^a_h[i][N]) ^ av_h[i][N] ^ (^b_v[N][i]) ^ bv_v[N][i];
    end
  end

endmodule

// File: tb/tb_systolic_array_param.sv
// Directed bench for systolic_array_param (N=4, DW=32, AW=64): an unsigned and
// a signed instance share all stimulus; expected values are hand-derived.
module tb_systolic_array_param;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 64;
  localparam int KW = 8;

  logic              Clk;
  logic              Reset;
  logic              Start;
  logic [KW-1:0]     K_Len;
  logic              In_Valid;
  logic [N*DW-1:0]   A_Col;
  logic [N*DW-1:0]   B_Row;
  logic              rdy_u, busy_u, done_u;
  logic              rdy_s, busy_s, done_s;
  logic [N*N*AW-1:0] res_u;
  logic [N*N*AW-1:0] res_s;

  logic [DW-1:0] a_m [N][N];
  logic [DW-1:0] b_m [N][N];
  int            checks;
  int            errors;
  int            load_bad;
  int            lat;
  int            busy_n;

  systolic_array_param #(.N(N), .DW(DW), .AW(AW), .KW(KW), .SIGNED(0)) u_dut_u (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .K_Len    (K_Len),
    .In_Valid (In_Valid),
    .In_Ready (rdy_u),
    .A_Col    (A_Col),
    .B_Row    (B_Row),
    .Busy     (busy_u),
    .Done     (done_u),
    .Result   (res_u)
  );

  systolic_array_param #(.N(N), .DW(DW), .AW(AW), .KW(KW), .SIGNED(1)) u_dut_s (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .K_Len    (K_Len),
    .In_Valid (In_Valid),
    .In_Ready (rdy_s),
    .A_Col    (A_Col),
    .B_Row    (B_Row),
    .Busy     (busy_s),
    .Done     (done_s),
    .Result   (res_s)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // 0: A = identity, B[k][j] = 10k+j   1: A[i][k] = i+1, B[k][j] = j+1
  // 2: A all -3 (0xFFFFFFFD), B all 5
  task automatic set_pattern(input int p);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        case (p)
          0: begin a_m[r][c] = (r == c) ? 32'd1 : 32'd0; b_m[r][c] = 32'(10 * r + c); end
          1: begin a_m[r][c] = 32'(r + 1);                b_m[r][c] = 32'(c + 1);        end
          default: begin a_m[r][c] = 32'hFFFF_FFFD;       b_m[r][c] = 32'd5;             end
        endcase
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the Start edge.
  task automatic start_job(input int k);
    Start = 1'b1;
    K_Len = KW'(k);
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Presents nb beats, optionally preceded each by an idle cycle carrying junk.
  task automatic feed(input int nb, input bit bubbles);
    for (int kk = 0; kk < nb; kk++) begin
      if (bubbles) begin
        In_Valid = 1'b0;
        A_Col    = {N{32'hDEAD_BEEF}};
        B_Row    = {N{32'hCAFE_F00D}};
        @(negedge Clk);
      end
      if (!busy_u || !rdy_u) load_bad++;
      In_Valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        A_Col[i*DW +: DW] = a_m[i][kk];
        B_Row[i*DW +: DW] = b_m[kk][i];
      end
      @(negedge Clk);
    end
    In_Valid = 1'b0;
  endtask

  // Counts falling edges until Done (bounded); optionally pulses Start once.
  task automatic wait_done(output int n, output int nb, input int start_at);
    n  = 0;
    nb = 0;
    while (!done_u && n < 40) begin
      if (busy_u) nb++;
      Start = (n == start_at);
      @(negedge Clk);
      n++;
    end
    Start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int p, input int k);
    logic [63:0] eu;
    logic [63:0] es;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        case (p)
          0: begin eu = 64'(10 * i + j);            es = eu;                    end
          1: begin eu = 64'(k * (i + 1) * (j + 1)); es = eu;                    end
          default: begin eu = 64'h9_FFFF_FFE2;      es = 64'hFFFF_FFFF_FFFF_FFE2; end
        endcase
        check($sformatf("%s_u_c%0d%0d", tag, i, j), res_u[(i*N+j)*AW +: AW], eu);
        check($sformatf("%s_s_c%0d%0d", tag, i, j), res_s[(i*N+j)*AW +: AW], es);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    load_bad = 0;
    Reset    = 1'b1;
    Start    = 1'b0;
    K_Len    = '0;
    In_Valid = 1'b0;
    A_Col    = '0;
    B_Row    = '0;
    set_pattern(0);

    // Reset state.
    repeat (2) @(negedge Clk);
    check("rst_busy",  64'(busy_u), 64'd0);
    check("rst_done",  64'(done_u), 64'd0);
    check("rst_ready", 64'(rdy_u),  64'd0);
    check("rst_res",   64'(|res_u), 64'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // Identity x B, K=4, one beat per cycle.
    start_job(4);
    feed(4, 1'b0);
    wait_done(lat, busy_n, -1);
    check("t1_load_busy_ready", 64'(load_bad), 64'd0);
    check("t1_latency", 64'(lat), 64'd7);
    check("t1_drain_busy", 64'(busy_n), 64'd7);
    check_result("t1", 0, 4);
    repeat (3) @(negedge Clk);
    check("t1_done_pulse", 64'(done_u), 64'd0);
    check("t1_idle_busy", 64'(busy_u), 64'd0);
    check("t1_hold_c23", res_u[(2*N+3)*AW +: AW], 64'd23);

    // Same matrices with a bubble before every beat.
    start_job(4);
    feed(4, 1'b1);
    wait_done(lat, busy_n, -1);
    check("t2_latency", 64'(lat), 64'd7);
    check_result("t2", 0, 4);

    // -3 * 5 over K=2: signed and unsigned interpretation of the same bits.
    set_pattern(2);
    start_job(2);
    feed(2, 1'b0);
    wait_done(lat, busy_n, -1);
    check("t3_latency", 64'(lat), 64'd7);
    check_result("t3", 2, 2);

    // K=0 with a Start pulse during DRAIN that must be ignored.
    start_job(0);
    wait_done(lat, busy_n, 2);
    check("t4_latency", 64'(lat), 64'd7);
    check("t4_busy_cycles", 64'(busy_n), 64'd7);
    check("t4_res_u", 64'(|res_u), 64'd0);
    check("t4_res_s", 64'(|res_s), 64'd0);
    @(negedge Clk);
    check("t4_done_pulse", 64'(done_u), 64'd0);

    // Reset after two beats of a K=4 job discards it.
    set_pattern(1);
    start_job(4);
    feed(2, 1'b0);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("t5_rst_busy",  64'(busy_u), 64'd0);
    check("t5_rst_done",  64'(done_u), 64'd0);
    check("t5_rst_ready", 64'(rdy_u),  64'd0);
    check("t5_rst_res",   64'(|res_u), 64'd0);

    // Start on the same edge as Reset is ignored.
    Reset = 1'b1;
    Start = 1'b1;
    K_Len = KW'(4);
    @(negedge Clk);
    Reset = 1'b0;
    Start = 1'b0;
    check("t5_rst_start_busy", 64'(busy_u), 64'd0);
    @(negedge Clk);
    check("t5_rst_start_ready", 64'(rdy_u), 64'd0);

    // Fresh K=4 job after the aborted one.
    set_pattern(0);
    start_job(4);
    feed(4, 1'b0);
    wait_done(lat, busy_n, -1);
    check("t5_latency", 64'(lat), 64'd7);
    check_result("t5", 0, 4);

    // Back-to-back: Start in the Done cycle with new data, K=3.
    check("t6_done_now", 64'(done_u), 64'd1);
    set_pattern(1);
    start_job(3);
    check("t6_busy", 64'(busy_u), 64'd1);
    check("t6_done_low", 64'(done_u), 64'd0);
    check("t6_cleared", 64'(|res_u), 64'd0);
    feed(3, 1'b0);
    wait_done(lat, busy_n, -1);
    check("t6_latency", 64'(lat), 64'd7);
    check_result("t6", 1, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
